// File: rtl/gfx256_pixel_writer.sv
// gfx256_pixel_writer: writes blended pixels into a 256-bit memory; optional depth test under GFX256_ZBUF_EN
module gfx256_pixel_writer #(
  parameter int point_width = 16,
  parameter int MDW = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [31:0]            target_base_i,
  input  logic [point_width-1:0] target_size_x_i,
  input  logic [5:0]             bpp_i,
  input  logic [5:0]             cbpp_i,
  input  logic [15:0]            coeff1_i,
  input  logic [9:0]             coeff2_i,
  input  logic [31:0]            zbuffer_base_i,
  input  logic                   zbuffer_enable_i,
  input  logic                   write_i,
  input  logic [point_width-1:0] pixel_x_i,
  input  logic [point_width-1:0] pixel_y_i,
  input  logic [point_width-1:0] pixel_z_i,
  input  logic [31:0]            pixel_color_i,
  input  logic                   strip_i,
  input  logic [MDW-1:0]         strip_color_i,
  output logic                   ack_o,
  output logic                   rd_request_o,
  output logic [31:0]            rd_addr_o,
  input  logic                   rd_ack_i,
  input  logic [MDW-1:0]         rd_data_i,
  output logic                   wr_request_o,
  output logic [31:0]            wr_addr_o,
  output logic [MDW-1:0]         wr_data_o,
  output logic [31:0]            wr_sel_o,
  input  logic                   wr_ack_i
);
  typedef enum logic [2:0] {IDLE, ADDR1, ADDR2, ZREAD, ZWRITE, CREAD, CWRITE, ACK} state_t;
  state_t r_state, w_next, w_cpath;
  logic [point_width-1:0] r_x, r_y, r_z;
  logic [31:0] r_color, r_lin, r_addr, r_rd_addr, r_wr_addr, r_wr_sel, w_sel;
  logic [MDW-1:0] r_strip_color, r_wr_data, w_mask, w_placed, w_merged;
  logic [7:0] r_mb;
  logic [37:0] w_bit;
  logic r_strip, r_rd_req, r_wr_req, w_aligned, w_rd_done, w_wr_done, w_ztest, w_unused;
  assign w_bit = 38'(r_lin) * 38'(bpp_i);
  assign w_aligned = bpp_i == 6'd8 || bpp_i == 6'd16 || bpp_i == 6'd32;
  assign w_rd_done = r_rd_req && rd_ack_i;
  assign w_wr_done = r_wr_req && wr_ack_i;
  assign w_cpath = (r_strip || w_aligned) ? CWRITE : CREAD;
  assign w_mask = ((MDW'(1) << bpp_i) - MDW'(1)) << r_mb;
  assign w_placed = (MDW'(r_color) << r_mb) & w_mask;
  assign w_merged = (rd_data_i & ~w_mask) | w_placed;
  assign w_sel = ((32'd1 << bpp_i[5:3]) - 32'd1) << r_mb[7:3];
`ifdef GFX256_ZBUF_EN
  logic [3:0] w_ze;
  logic [15:0] w_zstored;
  logic [31:0] w_zaddr;
  logic w_zpass;
  assign w_ze = r_lin[3:0];
  assign w_zaddr = zbuffer_base_i + 32'({r_lin[26:4], 5'b0});
  assign w_zstored = rd_data_i[{w_ze, 4'b0} +: 16];
  assign w_zpass = $signed(r_z) < $signed(w_zstored);
  assign w_ztest = zbuffer_enable_i;
  assign w_unused = ^{cbpp_i, coeff1_i, coeff2_i, w_bit[37:35]};
`else
  assign w_ztest = 1'b0;
  assign w_unused = ^{cbpp_i, coeff1_i, coeff2_i, w_bit[37:35], zbuffer_base_i, zbuffer_enable_i, r_z};
`endif
  assign ack_o = r_state == ACK;
  assign rd_request_o = r_rd_req;
  assign rd_addr_o = r_rd_addr;
  assign wr_request_o = r_wr_req;
  assign wr_addr_o = r_wr_addr;
  assign wr_data_o = r_wr_data;
  assign wr_sel_o = r_wr_sel;
  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state: address pipeline, optional depth test, then colour read/write
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   w_next = write_i ? ADDR1 : IDLE;
      ADDR1:  w_next = ADDR2;
      ADDR2:  w_next = bpp_i == 6'd0 ? ACK : w_ztest ? ZREAD : w_cpath;
`ifdef GFX256_ZBUF_EN
      ZREAD:  w_next = w_rd_done ? (w_zpass ? ZWRITE : ACK) : ZREAD;
      ZWRITE: w_next = w_wr_done ? w_cpath : ZWRITE;
`endif
      CREAD:  w_next = w_rd_done ? CWRITE : CREAD;
      CWRITE: w_next = w_wr_done ? ACK : CWRITE;
      default: w_next = IDLE;
    endcase
  end
  // pixel capture and two-stage word address / bit offset computation
  always_ff @(posedge clk_i) begin
    if (r_state == IDLE && write_i) begin
      r_x <= pixel_x_i;
      r_y <= pixel_y_i;
      r_z <= pixel_z_i;
      r_color <= pixel_color_i;
      r_strip <= strip_i;
      r_strip_color <= strip_color_i;
    end
    if (r_state == ADDR1) r_lin <= 32'(r_y) * 32'(target_size_x_i) + 32'(r_x);
    if (r_state == ADDR2) begin
      r_addr <= target_base_i + {w_bit[34:8], 5'b0};
      r_mb <= w_bit[7:0];
    end
  end
  // bus requests rise one cycle into their state and drop on the accepted ack
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_req <= 1'b0;
      r_wr_req <= 1'b0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_sel <= '1;
    end else begin
      r_rd_req <= (r_state == CREAD || r_state == ZREAD) && !w_rd_done;
      r_wr_req <= (r_state == CWRITE || r_state == ZWRITE) && !w_wr_done;
      if (r_state == CREAD) r_rd_addr <= r_addr;
      if (r_state == CREAD && w_rd_done) begin
        r_wr_data <= w_merged;
        r_wr_sel <= '1;
      end
      if (r_state == CWRITE) begin
        r_wr_addr <= r_addr;
        r_wr_data <= r_strip ? r_strip_color : w_aligned ? w_placed : r_wr_data;
        r_wr_sel <= r_strip ? '1 : w_aligned ? w_sel : r_wr_sel;
      end
`ifdef GFX256_ZBUF_EN
      if (r_state == ZREAD) r_rd_addr <= w_zaddr;
      if (r_state == ZWRITE) begin
        r_wr_addr <= w_zaddr;
        r_wr_data <= MDW'(r_z) << {w_ze, 4'b0};
        r_wr_sel <= 32'd3 << {w_ze, 1'b0};
      end
`endif
    end
  end
endmodule

// File: tb/tb_gfx256_pixel_writer.sv
// tb_gfx256_pixel_writer: randomized and directed checks of gfx256_pixel_writer against a bit-level memory model
module tb_gfx256_pixel_writer;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic [31:0] target_base_i = '0;
  logic [15:0] target_size_x_i = 16'd640;
  logic [5:0] bpp_i = 6'd32, cbpp_i = 6'd32;
  logic [15:0] coeff1_i = '0;
  logic [9:0] coeff2_i = '0;
  logic [31:0] zbuffer_base_i = '0;
  logic zbuffer_enable_i = 1'b0, write_i = 1'b0, strip_i = 1'b0;
  logic [15:0] pixel_x_i = '0, pixel_y_i = '0, pixel_z_i = '0;
  logic [31:0] pixel_color_i = '0;
  logic [255:0] strip_color_i = '0;
  logic ack_o, rd_request_o, wr_request_o;
  logic [31:0] rd_addr_o, wr_addr_o, wr_sel_o;
  logic [255:0] wr_data_o;
  logic rd_ack_i = 1'b0, wr_ack_i = 1'b0;
  logic [255:0] rd_data_i = '0;

  gfx256_pixel_writer dut (
    .clk_i(clk_i), .rst_i(rst_i), .target_base_i(target_base_i), .target_size_x_i(target_size_x_i),
    .bpp_i(bpp_i), .cbpp_i(cbpp_i), .coeff1_i(coeff1_i), .coeff2_i(coeff2_i),
    .zbuffer_base_i(zbuffer_base_i), .zbuffer_enable_i(zbuffer_enable_i), .write_i(write_i),
    .pixel_x_i(pixel_x_i), .pixel_y_i(pixel_y_i), .pixel_z_i(pixel_z_i), .pixel_color_i(pixel_color_i),
    .strip_i(strip_i), .strip_color_i(strip_color_i), .ack_o(ack_o),
    .rd_request_o(rd_request_o), .rd_addr_o(rd_addr_o), .rd_ack_i(rd_ack_i), .rd_data_i(rd_data_i),
    .wr_request_o(wr_request_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_sel_o(wr_sel_o),
    .wr_ack_i(wr_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {logic [31:0] a; logic [255:0] d; logic [31:0] s;} wr_t;
  logic [31:0] rd_log[$];
  wr_t wr_log[$];
  int tests = 0, fails = 0, acks = 0, overlap = 0, rd_delay = 0, wr_delay = 0;
  logic [255:0] rd_word = '0;
  logic [5:0] bpp_tab [0:8] = '{6'd0, 6'd1, 6'd2, 6'd4, 6'd8, 6'd12, 6'd16, 6'd24, 6'd32};

  // ack pulses and rd/wr overlap observed just after each edge
  always @(posedge clk_i) begin
    #1;
    if (ack_o) acks++;
    if (rd_request_o && wr_request_o) overlap++;
  end

  // read slave: returns rd_word after rd_delay cycles, abandons if the request drops
  initial forever begin
    @(negedge clk_i);
    if (rd_request_o) begin
      for (int i = 0; i < rd_delay && rd_request_o; i++) @(negedge clk_i);
      if (rd_request_o) begin
        rd_log.push_back(rd_addr_o);
        rd_data_i = rd_word;
        rd_ack_i = 1'b1;
        @(negedge clk_i);
        rd_ack_i = 1'b0;
      end
    end
  end

  // write slave: records each accepted write
  initial forever begin
    @(negedge clk_i);
    if (wr_request_o) begin
      for (int i = 0; i < wr_delay && wr_request_o; i++) @(negedge clk_i);
      if (wr_request_o) begin
        wr_log.push_back('{wr_addr_o, wr_data_o, wr_sel_o});
        wr_ack_i = 1'b1;
        @(negedge clk_i);
        wr_ack_i = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                       input logic [31:0] col, input logic s, input logic [255:0] sw);
    int a0;
    rd_log.delete();
    wr_log.delete();
    a0 = acks;
    pixel_x_i = x;
    pixel_y_i = y;
    pixel_z_i = z;
    pixel_color_i = col;
    strip_i = s;
    strip_color_i = sw;
    write_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (ack_o) break;
    end
    check("ack_seen", 256'(ack_o), 256'd1);
    write_i = 1'b0;
    @(negedge clk_i);
    check("ack_single_pulse", 256'(acks - a0), 256'd1);
    check("ack_low_after", 256'(ack_o), 256'd0);
  endtask

  task automatic check_colour(input logic [15:0] x, input logic [15:0] y, input logic [31:0] col,
                              input logic s, input logic [255:0] sw);
    longint lin, bits;
    int mb, nr, nw;
    logic [31:0] wa, es;
    logic [255:0] ed, m;
    logic alg;
    lin = longint'(y) * longint'(target_size_x_i) + longint'(x);
    bits = lin * longint'(bpp_i);
    wa = target_base_i + 32'((bits / 256) * 32);
    mb = int'(bits % 256);
    alg = bpp_i == 6'd8 || bpp_i == 6'd16 || bpp_i == 6'd32;
    nr = (bpp_i == 6'd0 || s || alg) ? 0 : 1;
    nw = bpp_i == 6'd0 ? 0 : 1;
    check("rd_count", 256'(rd_log.size()), 256'(nr));
    check("wr_count", 256'(wr_log.size()), 256'(nw));
    if (nr == 1 && rd_log.size() == 1) check("rd_addr", 256'(rd_log[0]), 256'(wa));
    if (nw == 1 && wr_log.size() == 1) begin
      es = '1;
      m = '1;
      for (int i = 0; i < 256; i++)
        ed[i] = (i >= mb && i < mb + int'(bpp_i)) ? ((i - mb < 32) ? col[i - mb] : 1'b0) : rd_word[i];
      if (s) ed = sw;
      else if (alg) begin
        es = '0;
        m = '0;
        for (int b = mb / 8; b < (mb + int'(bpp_i)) / 8; b++) begin
          es[b] = 1'b1;
          m[8*b +: 8] = 8'hFF;
        end
      end
      check("wr_addr", 256'(wr_log[0].a), 256'(wa));
      check("wr_sel", 256'(wr_log[0].s), 256'(es));
      check("wr_data", wr_log[0].d & m, ed & m);
    end
  endtask

  initial begin
    logic [255:0] exp, sw;
    logic [15:0] x, y;
    logic [31:0] col;
    logic s;
    int a0;
    repeat (3) @(negedge clk_i);
    check("rst_ack", 256'(ack_o), 256'd0);
    check("rst_rd_req", 256'(rd_request_o), 256'd0);
    check("rst_wr_req", 256'(wr_request_o), 256'd0);
    check("rst_rd_addr", 256'(rd_addr_o), 256'd0);
    check("rst_wr_addr", 256'(wr_addr_o), 256'd0);
    check("rst_wr_data", wr_data_o, 256'd0);
    check("rst_wr_sel", 256'(wr_sel_o), 256'(32'hFFFFFFFF));
    rst_i = 1'b0;
    @(negedge clk_i);
    // 32bpp pixel at (3,1) on a 640-wide surface
    drive(16'd3, 16'd1, 16'd0, 32'hDEADBEEF, 1'b0, '0);
    check_colour(16'd3, 16'd1, 32'hDEADBEEF, 1'b0, '0);
    if (wr_log.size() == 1) begin
      check("t1_addr", 256'(wr_log[0].a), 256'(32'h00000A00));
      check("t1_sel", 256'(wr_log[0].s), 256'(32'h0000F000));
      check("t1_data", wr_log[0].d[127:96], 256'(32'hDEADBEEF));
    end
    // reset while a 12bpp read is outstanding
    bpp_i = 6'd12;
    rd_word = '1;
    rd_delay = 7;
    rd_log.delete();
    a0 = acks;
    pixel_x_i = 16'd2;
    pixel_y_i = 16'd0;
    pixel_color_i = 32'h55555ABC;
    strip_i = 1'b0;
    write_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (rd_request_o) break;
    end
    check("rst_mid_req_seen", 256'(rd_request_o), 256'd1);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    write_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_mid_rd_req", 256'(rd_request_o), 256'd0);
    check("rst_mid_wr_req", 256'(wr_request_o), 256'd0);
    repeat (10) @(negedge clk_i);
    check("rst_mid_no_ack", 256'(acks - a0), 256'd0);
    check("rst_mid_no_rd", 256'(rd_log.size()), 256'd0);
    // 12bpp read-modify-write at (2,0) over an all-ones word
    rd_delay = 1;
    drive(16'd2, 16'd0, 16'd0, 32'h55555ABC, 1'b0, '0);
    check_colour(16'd2, 16'd0, 32'h55555ABC, 1'b0, '0);
    exp = '1;
    exp[35:24] = 12'hABC;
    if (wr_log.size() == 1) check("t2_data", wr_log[0].d, exp);
    // strip word write
    bpp_i = 6'd8;
    sw = {8{32'h11223344}};
    drive(16'd7, 16'd4, 16'd0, 32'h0, 1'b1, sw);
    check_colour(16'd7, 16'd4, 32'h0, 1'b1, sw);
    if (wr_log.size() == 1) check("t3_data", wr_log[0].d, sw);
`ifdef GFX256_ZBUF_EN
    // depth test pass then fail, entry 5 of the first depth word
    bpp_i = 6'd32;
    target_base_i = '0;
    target_size_x_i = 16'd640;
    zbuffer_base_i = 32'h00010000;
    zbuffer_enable_i = 1'b1;
    rd_word = '0;
    rd_word[95:80] = 16'd100;
    drive(16'd5, 16'd0, 16'd50, 32'hCAFEF00D, 1'b0, '0);
    check("z_pass_rd_count", 256'(rd_log.size()), 256'd1);
    check("z_pass_wr_count", 256'(wr_log.size()), 256'd2);
    if (rd_log.size() == 1) check("z_rd_addr", 256'(rd_log[0]), 256'(32'h00010000));
    if (wr_log.size() == 2) begin
      check("z_wr_addr", 256'(wr_log[0].a), 256'(32'h00010000));
      check("z_wr_sel", 256'(wr_log[0].s), 256'(32'h00000C00));
      check("z_wr_data", 256'(wr_log[0].d[95:80]), 256'd50);
      check("z_col_sel", 256'(wr_log[1].s), 256'(32'h00F00000));
      check("z_col_data", 256'(wr_log[1].d[191:160]), 256'(32'hCAFEF00D));
    end
    drive(16'd5, 16'd0, 16'd200, 32'hCAFEF00D, 1'b0, '0);
    check("z_fail_rd_count", 256'(rd_log.size()), 256'd1);
    check("z_fail_wr_count", 256'(wr_log.size()), 256'd0);
    zbuffer_enable_i = 1'b0;
`endif
    // randomized pixels across formats, surfaces and bus latencies
    for (int n = 0; n < 40; n++) begin
      bpp_i = bpp_tab[$urandom_range(8)];
      target_size_x_i = 16'($urandom_range(300, 1));
      target_base_i = $urandom & 32'hFFFFFFE0;
      x = '0;
      y = '0;
      for (int k = 0; k < 64; k++) begin
        y = 16'($urandom_range(40));
        x = 16'($urandom_range(int'(target_size_x_i) - 1));
        if (((longint'(y) * target_size_x_i + x) * bpp_i) % 256 + bpp_i <= 256) break;
      end
      for (int k = 0; k < 8; k++) begin
        rd_word[32*k +: 32] = $urandom;
        sw[32*k +: 32] = $urandom;
      end
      col = $urandom;
      s = $urandom_range(5) == 0;
      rd_delay = $urandom_range(4);
      wr_delay = $urandom_range(4);
      drive(x, y, 16'd0, col, s, sw);
      check_colour(x, y, col, s, sw);
    end
    check("rd_wr_overlap", 256'(overlap), 256'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
